// File: rtl/decerr_slave.sv
// AXI default slave: accepts any write or read burst and answers it with a fixed
// error response and the transaction's ID. It also keeps a saturating count of terminated transactions.
module decerr_slave #(
  parameter int unsigned    ID_W   = 8,
  parameter int unsigned    DATA_W = 32,
  parameter int unsigned    LEN_W  = 4,
  parameter logic [1:0]     RESP   = 2'b11,
  parameter int unsigned    CNT_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic [ID_W-1:0]  aw_id_q, ar_id_q;
  logic [LEN_W-1:0] rcnt;
  logic             b_hs, r_last_hs;
  logic [1:0]       inc;
  logic [CNT_W:0]   cnt_sum;

  // AWLEN is informational only; WLAST alone ends the write burst.
  logic unused_awlen;
  assign unused_awlen = ^AWLEN;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always_ff blocks run in.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BID     = '0;
    BRESP   = 2'b00;
    unique case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && WLAST) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BID    = aw_id_q;
        BRESP  = RESP;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RID     = '0;
    RDATA   = '0;
    RRESP   = 2'b00;
    RLAST   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RID    = ar_id_q;
        RRESP  = RESP;
        RLAST  = (rcnt == '0);
        if (RREADY && rcnt == '0) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_id_q <= '0;
      ar_id_q <= '0;
      rcnt    <= '0;
    end else begin
      if (w_state == W_IDLE && AWVALID) aw_id_q <= AWID;
      if (r_state == R_IDLE && ARVALID) begin
        ar_id_q <= ARID;
        rcnt    <= ARLEN;
      end else if (r_state == R_DATA && RREADY && rcnt != '0) begin
        rcnt <= rcnt - 1'b1;
      end
    end
  end

  // Sum is one bit wider than the counter so a +2 that crosses the maximum is caught.
  assign b_hs      = (w_state == W_RESP) && BREADY;
  assign r_last_hs = (r_state == R_DATA) && RREADY && (rcnt == '0);
  assign inc       = {1'b0, b_hs} + {1'b0, r_last_hs};
  assign cnt_sum   = {1'b0, err_cnt} + (CNT_W+1)'(inc);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) err_cnt <= '0;
    else          err_cnt <= cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_decerr_slave.sv
// Directed bench for decerr_slave: write, burst read, stalled read, concurrent
// completion with counter saturation (second instance, CNT_W=2), and mid-burst reset.
module tb_decerr_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID, ARID;
  logic [3:0]  AWLEN, ARLEN;
  logic        AWVALID, WLAST, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [7:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [15:0] err_cnt;

  logic        s_awready, s_wready, s_bvalid, s_arready, s_rlast, s_rvalid;
  logic [7:0]  s_bid, s_rid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [1:0]  s_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  decerr_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .err_cnt(err_cnt)
  );

  decerr_slave #(.CNT_W(2)) dut_small (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(s_awready),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(s_wready),
    .BID(s_bid), .BRESP(s_bresp), .BVALID(s_bvalid), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(s_arready),
    .RID(s_rid), .RDATA(s_rdata), .RRESP(s_rresp), .RLAST(s_rlast), .RVALID(s_rvalid),
    .RREADY(RREADY), .err_cnt(s_err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  // Single-beat write with a W beat offered early; expects err_cnt=exp_cnt afterwards.
  task automatic do_write(input logic [7:0] id, input logic [15:0] exp_cnt);
    AWID = id; AWLEN = 4'd0; AWVALID = 1'b1; WVALID = 1'b1; WLAST = 1'b1;
    check("wready_before_aw", WREADY, 1'b0);
    tick();
    AWVALID = 1'b0;
    check("wr_awready_busy", AWREADY, 1'b0);
    check("wr_wready", WREADY, 1'b1);
    check("wr_bvalid_early", BVALID, 1'b0);
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    check("wr_bvalid", BVALID, 1'b1);
    check("wr_bid", BID, id);
    check("wr_bresp", BRESP, 2'b11);
    check("wr_wready_resp", WREADY, 1'b0);
    tick();
    check("wr_bvalid_hold", BVALID, 1'b1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("wr_bvalid_done", BVALID, 1'b0);
    check("wr_awready_back", AWREADY, 1'b1);
    check("wr_err_cnt", err_cnt, exp_cnt);
  endtask

  initial begin
    logic [4:0] pat;
    int         beat;

    ARESETn = 1'b0;
    AWID = '0; AWLEN = '0; AWVALID = 1'b0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    tick();
    check("rst_awready", AWREADY, 1'b1);
    check("rst_arready", ARREADY, 1'b1);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    tick();
    ARESETn = 1'b1;
    tick();

    // Single write, ID 0x5A.
    do_write(8'h5A, 16'd1);

    // Read ARID=0x33, ARLEN=3, RREADY held high.
    ARID = 8'h33; ARLEN = 4'd3; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rd4_rvalid", RVALID, 1'b1);
      check("rd4_rid", RID, 8'h33);
      check("rd4_rdata", RDATA, 32'd0);
      check("rd4_rresp", RRESP, 2'b11);
      check("rd4_rlast", RLAST, (i == 3));
      check("rd4_arready", ARREADY, 1'b0);
      tick();
    end
    RREADY = 1'b0;
    check("rd4_rvalid_done", RVALID, 1'b0);
    check("rd4_arready_back", ARREADY, 1'b1);
    check("rd4_err_cnt", err_cnt, 16'd2);
    check("small_err_cnt_2", s_err_cnt, 2'd2);

    // Concurrent write and single-beat read, B and last R in the same cycle.
    AWID = 8'h11; AWVALID = 1'b1; ARID = 8'h22; ARLEN = 4'd0; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b1; WLAST = 1'b1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    check("cc_bvalid", BVALID, 1'b1);
    check("cc_rvalid", RVALID, 1'b1);
    check("cc_rlast", RLAST, 1'b1);
    check("cc_bid", BID, 8'h11);
    check("cc_rid", RID, 8'h22);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    check("cc_err_cnt_plus2", err_cnt, 16'd4);
    check("cc_small_saturate", s_err_cnt, 2'd3);

    // Read ARLEN=2 with RREADY pattern 1,0,0,1,1.
    ARID = 8'h44; ARLEN = 4'd2; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    pat  = 5'b11001;  // bit k = RREADY in cycle k
    beat = 0;
    for (int k = 0; k < 5; k++) begin
      check("st_rvalid", RVALID, 1'b1);
      check("st_rid", RID, 8'h44);
      check("st_rlast", RLAST, (beat == 2));
      RREADY = pat[k];
      tick();
      if (pat[k]) beat++;
    end
    RREADY = 1'b0;
    check("st_beats", beat, 3);
    check("st_rvalid_done", RVALID, 1'b0);
    check("st_err_cnt", err_cnt, 16'd5);
    check("st_small_held", s_err_cnt, 2'd3);

    // Reset mid-read (rcnt=2) and mid-write (W_DATA).
    AWID = 8'h66; AWVALID = 1'b1; ARID = 8'h55; ARLEN = 4'd3; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0; RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("mr_rvalid_before", RVALID, 1'b1);
    check("mr_rlast_before", RLAST, 1'b0);
    check("mr_wready_before", WREADY, 1'b1);
    #2 ARESETn = 1'b0;
    #1;
    check("mr_rvalid", RVALID, 1'b0);
    check("mr_wready", WREADY, 1'b0);
    check("mr_bvalid", BVALID, 1'b0);
    check("mr_awready", AWREADY, 1'b1);
    check("mr_arready", ARREADY, 1'b1);
    check("mr_err_cnt", err_cnt, 16'd0);
    check("mr_small_err_cnt", s_err_cnt, 2'd0);
    tick();
    ARESETn = 1'b1;
    tick();
    check("mr_no_rresp", RVALID, 1'b0);
    check("mr_no_bresp", BVALID, 1'b0);

    // Next transactions complete normally.
    do_write(8'h77, 16'd1);
    ARID = 8'h0F; ARLEN = 4'd1; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    check("pr_rid", RID, 8'h0F);
    check("pr_rlast0", RLAST, 1'b0);
    tick();
    check("pr_rlast1", RLAST, 1'b1);
    tick();
    RREADY = 1'b0;
    check("pr_rvalid_done", RVALID, 1'b0);
    check("pr_err_cnt", err_cnt, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
